// File: rtl/cont_edge_counter_if.sv
// cont_edge_counter_if: single-outstanding request/acknowledge counter readout port
interface cont_edge_counter_if #(parameter int CNT_W = 8);
  logic             rd_req;
  logic [1:0]       rd_sel;
  logic             rd_ack;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  modport master (output rd_req, rd_sel, rd_ack, input rd_valid, rd_data);
  modport slave (input rd_req, rd_sel, rd_ack, output rd_valid, rd_data);
endinterface

// File: rtl/cont_edge_counter.sv
// cont_edge_counter: registered rising-edge counters on d/y/p with saturating counts and snapshot readout
module cont_edge_counter #(
  parameter int CNT_W     = 8,
  parameter bit CLR_ON_RD = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               d_in,
  input  logic               y_in,
  input  logic               p_in,
  cont_edge_counter_if.slave rd,
  output logic [2:0]         ovf
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t           state, nxt;
  logic [2:0]       s, q, rise, rd_clr;
  logic [CNT_W-1:0] cnt [3];
  logic [CNT_W-1:0] snap;
  logic             accept;
  assign rise        = s & ~q;
  assign rd.rd_valid = (state == HOLD);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    accept = (state == IDLE) && rd.rd_req;
    nxt    = accept ? HOLD : (state == HOLD && rd.rd_ack) ? IDLE : state;
    snap   = rd.rd_sel[1] ? (rd.rd_sel[0] ? CNT_W'(ovf) : cnt[2]) : cnt[rd.rd_sel[0]];
    for (int i = 0; i < 3; i++) rd_clr[i] = CLR_ON_RD && accept && (rd.rd_sel == 2'(i));
  end
  // read-clear restarts at 1 when the same cycle carries an edge, so no edge is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      s          <= '0;
      q          <= '0;
      ovf        <= '0;
      rd.rd_data <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s <= {p_in, y_in, d_in};
      q <= s;
      if (accept) rd.rd_data <= snap;
      for (int i = 0; i < 3; i++) begin
        if (clear) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (rd_clr[i]) begin
          cnt[i] <= CNT_W'(rise[i]);
          ovf[i] <= 1'b0;
        end else if (rise[i]) begin
          cnt[i] <= &cnt[i] ? cnt[i] : cnt[i] + 1'b1;
          ovf[i] <= ovf[i] | (&cnt[i]);
        end
      end
    end
  end
endmodule

// File: tb/tb_cont_edge_counter.sv
// tb_cont_edge_counter: directed plus random check of two counter instances against an event-count model
module tb_cont_edge_counter;
  localparam int W    = 4;
  localparam int MAXV = 15;
  logic       clk = 0, rst = 1, clear = 0, d_in = 0, y_in = 0, p_in = 0;
  logic       rd_req = 0, rd_ack = 0;
  logic [1:0] rd_sel = 0;
  logic [2:0] ovf0, ovf1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  cont_edge_counter_if #(.CNT_W(W)) bus0 ();
  cont_edge_counter_if #(.CNT_W(W)) bus1 ();
  assign bus0.rd_req = rd_req;
  assign bus0.rd_sel = rd_sel;
  assign bus0.rd_ack = rd_ack;
  assign bus1.rd_req = rd_req;
  assign bus1.rd_sel = rd_sel;
  assign bus1.rd_ack = rd_ack;
  cont_edge_counter #(.CNT_W(W), .CLR_ON_RD(1'b0)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .d_in(d_in), .y_in(y_in), .p_in(p_in), .rd(bus0), .ovf(ovf0));
  cont_edge_counter #(.CNT_W(W), .CLR_ON_RD(1'b1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .d_in(d_in), .y_in(y_in), .p_in(p_in), .rd(bus1), .ovf(ovf1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  // model: raw edge totals per channel; count and overflow derive from them arithmetically
  int       ev [2][3];
  bit [2:0] ms, mq;
  bit       mhold [2];
  int       mdata [2];
  bit       started = 0;
  function automatic int mcnt(input int e);
    return e > MAXV ? MAXV : e;
  endfunction
  function automatic int movf(input int k);
    int r = 0;
    for (int i = 0; i < 3; i++) if (ev[k][i] > MAXV) r |= 1 << i;
    return r;
  endfunction
  always @(posedge clk) begin
    bit [2:0] rise;
    bit acc;
    started = 1;
    if (rst) begin
      ms = 0;
      mq = 0;
      for (int k = 0; k < 2; k++) begin
        mhold[k] = 0;
        mdata[k] = 0;
        for (int i = 0; i < 3; i++) ev[k][i] = 0;
      end
    end else begin
      rise = ms & ~mq;
      for (int k = 0; k < 2; k++) begin
        acc = !mhold[k] && rd_req;
        if (acc) begin
          mdata[k] = (rd_sel == 3) ? movf(k) : mcnt(ev[k][rd_sel]);
          mhold[k] = 1;
        end else if (mhold[k] && rd_ack) mhold[k] = 0;
        for (int i = 0; i < 3; i++)
          if (clear) ev[k][i] = 0;
          else if (k == 1 && acc && rd_sel == 2'(i)) ev[k][i] = int'(rise[i]);
          else ev[k][i] += int'(rise[i]);
      end
      mq = ms;
      ms = {p_in, y_in, d_in};
    end
  end
  always @(negedge clk) if (started) begin
    chk("valid0", bus0.rd_valid, mhold[0]);
    chk("data0", bus0.rd_data, mdata[0]);
    chk("ovf0", ovf0, movf(0));
    chk("valid1", bus1.rd_valid, mhold[1]);
    chk("data1", bus1.rd_data, mdata[1]);
    chk("ovf1", ovf1, movf(1));
  end
  task automatic set_ch(input int ch, input logic v);
    if (ch == 0) d_in = v;
    else if (ch == 1) y_in = v;
    else p_in = v;
  endtask
  task automatic pulse(input int ch, input int n);
    repeat (n) begin
      set_ch(ch, 1'b1);
      @(negedge clk);
      set_ch(ch, 1'b0);
      @(negedge clk);
    end
  endtask
  task automatic rd_start(input int sel);
    rd_sel = 2'(sel);
    rd_req = 1;
    @(negedge clk);
    rd_req = 0;
  endtask
  task automatic rd_end();
    rd_ack = 1;
    @(negedge clk);
    rd_ack = 0;
  endtask
  task automatic read_exp(input string tag, input int sel, input int e0, input int e1);
    rd_start(sel);
    chk({tag, "_v"}, bus0.rd_valid, 1);
    chk(tag, bus0.rd_data, e0);
    chk({tag, "_clr"}, bus1.rd_data, e1);
    rd_end();
    chk({tag, "_idle"}, bus0.rd_valid, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_valid", bus0.rd_valid, 0);
    chk("rst_data", bus0.rd_data, 0);
    chk("rst_ovf", ovf0, 0);
    read_exp("rst_rd", 0, 0, 0);
    pulse(0, 5);
    read_exp("d5", 0, 5, 5);
    read_exp("y0", 1, 0, 0);
    read_exp("p0", 2, 0, 0);
    pulse(2, 15);
    chk("ovf_at15", ovf0, 0);
    pulse(2, 1);
    chk("ovf_at16", ovf0, 4);
    pulse(2, 1);
    read_exp("ovf_rd", 3, 4, 4);
    read_exp("p_sat", 2, 15, 15);
    clear = 1;
    @(negedge clk);
    clear = 0;
    read_exp("p_clr", 2, 0, 0);
    chk("ovf_clr", ovf0, 0);
    pulse(1, 7);
    rd_start(1);
    chk("hs7", bus0.rd_data, 7);
    rd_sel = 0;
    rd_req = 1;
    pulse(1, 3);
    rd_req = 0;
    chk("hs_hold_v", bus0.rd_valid, 1);
    chk("hs_hold_d", bus0.rd_data, 7);
    rd_end();
    chk("hs_ack", bus0.rd_valid, 0);
    read_exp("hs10", 1, 10, 3);
    d_in = 1;
    @(negedge clk);
    d_in = 0;
    clear = 1;
    @(negedge clk);
    clear = 0;
    read_exp("clr_edge", 0, 0, 0);
    pulse(0, 3);
    d_in = 1;
    @(negedge clk);
    d_in = 0;
    rd_start(0);
    chk("crd_old0", bus0.rd_data, 3);
    chk("crd_old1", bus1.rd_data, 3);
    rd_end();
    read_exp("crd_new", 0, 4, 1);
    rd_start(1);
    rst = 1;
    d_in = 1;
    @(negedge clk);
    chk("rst_hold0", bus0.rd_valid, 0);
    chk("rst_hold1", bus1.rd_valid, 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    read_exp("rst_high", 0, 1, 1);
    d_in = 0;
    read_exp("rst_y", 1, 0, 0);
    for (int n = 0; n < 800; n++) begin
      d_in   = 1'($urandom_range(0, 1));
      y_in   = 1'($urandom_range(0, 1));
      p_in   = 1'($urandom_range(0, 1));
      clear  = ($urandom_range(0, 63) == 0);
      rd_req = 1'($urandom_range(0, 1));
      rd_ack = ($urandom_range(0, 3) == 0);
      rd_sel = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    {d_in, y_in, p_in, clear, rd_req, rd_ack} = '0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
